// File: rtl/mux_sync_src.sv
// Source-side launcher for a MUX-based data synchronizer: captures a word, holds it on
// data_o and runs a 4-phase req/ack handshake against a synchronized acknowledge.
module mux_sync_src #(
    parameter int DATA_WIDTH = 32,
    parameter int SYNC_DEPTH = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sync_ctrl_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int T_LAST  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = T_LAST[CNT_W-1:0];

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]            state_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  sync_r;
    logic                  done_r;
    logic                  err_r;
    logic                  timed_out_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [SYNC_DEPTH-1:0] ack_sync_r;
    logic                  ack_s;

    // Bring the destination acknowledge into this clock domain.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ack_sync_r <= '0;
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_DEPTH-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_r[SYNC_DEPTH-1];

    // Handshake FSM with registered request, data and status pulses.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            sync_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            timed_out_r <= 1'b0;
            cnt_r       <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        data_r  <= data_i;
                        state_r <= ST_SETUP;
                    end
                end
                // Data has been stable for a full cycle before the request rises.
                ST_SETUP: begin
                    sync_r  <= 1'b1;
                    cnt_r   <= '0;
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack_s) begin
                        sync_r  <= 1'b0;
                        state_r <= ST_RELEASE;
                    end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                        sync_r      <= 1'b0;
                        err_r       <= 1'b1;
                        timed_out_r <= 1'b1;
                        state_r     <= ST_RELEASE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        done_r      <= ~timed_out_r;
                        timed_out_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    sync_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);
    assign data_o      = data_r;
    assign sync_ctrl_o = sync_r;
    assign done_o      = done_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_mux_sync_src.sv
// Directed bench for mux_sync_src: one instance without timeout, one with TIMEOUT=8.
module tb_mux_sync_src;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] a_data_i, b_data_i;
    logic        a_valid, b_valid, a_ack, b_ack;
    logic        a_ready, b_ready, a_sync, b_sync, a_busy, b_busy;
    logic        a_done, b_done, a_err, b_err;
    logic [31:0] a_data_o, b_data_o;

    int n_checks = 0;
    int n_errors = 0;
    int a_done_cnt = 0, a_err_cnt = 0, b_done_cnt = 0, b_err_cnt = 0;

    always #5 clk = ~clk;

    mux_sync_src #(.DATA_WIDTH(32), .SYNC_DEPTH(2), .TIMEOUT(0)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .data_i(a_data_i), .valid_i(a_valid),
        .ready_o(a_ready), .data_o(a_data_o), .sync_ctrl_o(a_sync), .ack_i(a_ack),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
    );

    mux_sync_src #(.DATA_WIDTH(32), .SYNC_DEPTH(2), .TIMEOUT(8)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .data_i(b_data_i), .valid_i(b_valid),
        .ready_o(b_ready), .data_o(b_data_o), .sync_ctrl_o(b_sync), .ack_i(b_ack),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_cnt++;
        if (a_err  === 1'b1) a_err_cnt++;
        if (b_done === 1'b1) b_done_cnt++;
        if (b_err  === 1'b1) b_err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge E; ack rises after E+1, falls after E+4.
    task automatic a_xfer(input logic [31:0] exp);
        step(); chk("x_sync_up", a_sync, 1); chk("x_data1", a_data_o, exp);
        a_ack = 1'b1;
        step(); chk("x_sync_e2", a_sync, 1);
        step(); chk("x_sync_e3", a_sync, 1); chk("x_data3", a_data_o, exp);
        step(); chk("x_sync_down", a_sync, 0); chk("x_busy4", a_busy, 1);
        a_ack = 1'b0;
        step(); chk("x_done5", a_done, 0);
        step(); chk("x_busy6", a_busy, 1); chk("x_data6", a_data_o, exp);
        step(); chk("x_done7", a_done, 1); chk("x_ready7", a_ready, 1);
        chk("x_data7", a_data_o, exp);
    endtask

    initial begin
        int d0;
        rstn = 1'b0;
        a_data_i = 32'h0; b_data_i = 32'h0;
        a_valid = 1'b0; b_valid = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
        step(); step();
        chk("rst_data", a_data_o, 32'h0); chk("rst_sync", a_sync, 0);
        chk("rst_ready", a_ready, 1);     chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);       chk("rst_err", a_err, 0);
        chk("rst_b_sync", b_sync, 0);     chk("rst_b_ready", b_ready, 1);
        rstn = 1'b1;
        step();

        // ack toggling in IDLE must not move the FSM
        for (int i = 0; i < 6; i++) begin
            a_ack = i[0];
            step(); chk("idle_ready", a_ready, 1); chk("idle_sync", a_sync, 0);
        end
        a_ack = 1'b0;
        step(); step(); step();
        chk("idle_done", a_done_cnt, 0);

        // Basic transfer with a REQ-time valid pulse that must be ignored
        a_valid = 1'b1; a_data_i = 32'hDEAD_BEEF;
        step(); chk("b_data", a_data_o, 32'hDEAD_BEEF); chk("b_setup_sync", a_sync, 0);
        chk("b_busy", a_busy, 1); chk("b_ready", a_ready, 0);
        a_valid = 1'b0;
        step(); chk("b_sync_rise", a_sync, 1);
        a_valid = 1'b1; a_data_i = 32'h0000_0055;
        step(); a_valid = 1'b0; chk("b_ign55", a_data_o, 32'hDEAD_BEEF);
        step(); a_ack = 1'b1;
        step(); chk("b_sync_A", a_sync, 1);
        step(); chk("b_sync_A1", a_sync, 1);
        step(); chk("b_sync_A2", a_sync, 0); chk("b_data_rel", a_data_o, 32'hDEAD_BEEF);
        step(); step(); a_ack = 1'b0;
        step(); chk("b_done_F", a_done, 0); chk("b_busy_F", a_busy, 1);
        step(); chk("b_done_F1", a_done, 0);
        step(); chk("b_done_F2", a_done, 1); chk("b_ready_F2", a_ready, 1);
        step(); chk("b_done_F3", a_done, 0); chk("b_done_cnt", a_done_cnt, 1);
        chk("b_data_idle", a_data_o, 32'hDEAD_BEEF);

        // Back-to-back with valid held high
        d0 = a_done_cnt;
        a_valid = 1'b1; a_data_i = 32'h1;
        step(); chk("bb_data1", a_data_o, 32'h1);
        a_data_i = 32'h2;
        a_xfer(32'h1);
        step(); chk("bb_data2", a_data_o, 32'h2); chk("bb_busy2", a_busy, 1);
        a_valid = 1'b0;
        a_xfer(32'h2);
        step(); chk("bb_done_cnt", a_done_cnt - d0, 2); chk("bb_err_cnt", a_err_cnt, 0);

        // No timeout when disabled, then reset mid-REQ
        a_valid = 1'b1; a_data_i = 32'hA5A5_A5A5;
        step(); a_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("nt_sync", a_sync, 1); chk("nt_err", a_err_cnt, 0);
        rstn = 1'b0;
        step(); rstn = 1'b1;
        chk("mr_sync", a_sync, 0); chk("mr_data", a_data_o, 32'h0);
        chk("mr_busy", a_busy, 0); chk("mr_ready", a_ready, 1);
        step(); step();
        chk("mr_done_cnt", a_done_cnt, 3); chk("mr_err_cnt", a_err_cnt, 0);

        // Timeout, TIMEOUT=8, ack never asserted
        b_valid = 1'b1; b_data_i = 32'h1234_5678;
        step(); b_valid = 1'b0; chk("to_data", b_data_o, 32'h1234_5678);
        for (int i = 1; i <= 8; i++) begin
            step(); chk("to_sync_hi", b_sync, 1); chk("to_err_lo", b_err, 0);
        end
        step(); chk("to_sync_lo", b_sync, 0); chk("to_err", b_err, 1); chk("to_busy", b_busy, 1);
        step(); chk("to_ready", b_ready, 1); chk("to_err_off", b_err, 0);
        chk("to_err_cnt", b_err_cnt, 1); chk("to_done_cnt", b_done_cnt, 0);

        // Late ack around the timeout: RELEASE waits for ack_s to drop
        b_valid = 1'b1; b_data_i = 32'h0F0F_0F0F;
        step(); b_valid = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        b_ack = 1'b1;
        step(); chk("la_sync8", b_sync, 1);
        step(); chk("la_err", b_err, 1); chk("la_sync9", b_sync, 0);
        for (int i = 10; i <= 12; i++) begin
            step(); chk("la_wait", b_busy, 1);
        end
        b_ack = 1'b0;
        step(); chk("la_busy13", b_busy, 1);
        step(); chk("la_busy14", b_busy, 1);
        step(); chk("la_ready", b_ready, 1); chk("la_done", b_done, 0);
        step();
        chk("la_done_cnt", b_done_cnt, 0); chk("la_err_cnt", b_err_cnt, 2);
        chk("la_data", b_data_o, 32'h0F0F_0F0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
